// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the three-road lamp monitor.
// The decoder turns a raw lamp vector into legality, fault causes and the green road.
package semaforo_pkg;

    typedef enum logic [1:0] {
        ROAD_NONE = 2'd0,
        ROAD_A    = 2'd1,
        ROAD_B    = 2'd2,
        ROAD_C    = 2'd3
    } road_t;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    localparam int FC_PAIR  = 0;
    localparam int FC_MULTI = 1;
    localparam int LAMP_W   = 6;

    typedef struct packed {
        logic       legal;
        logic [1:0] causes;
        road_t      green;
    } lamp_info_t;

    // Vector order is {VDA,VMA,VDB,VMB,VDC,VMC}; road A ends up in bit 0 of vd/vm.
    function automatic lamp_info_t decode_lamps(input logic [LAMP_W-1:0] v);
        lamp_info_t r;
        logic [2:0] vd;
        logic [2:0] vm;
        vd = {v[1], v[3], v[5]};
        vm = {v[0], v[2], v[4]};
        r.causes           = 2'b00;
        r.causes[FC_PAIR]  = |(~(vd ^ vm));
        r.causes[FC_MULTI] = ((vd & (vd - 3'd1)) != 3'd0);
        r.legal            = (r.causes == 2'b00);
        if (vd[0]) begin
            r.green = ROAD_A;
        end else if (vd[1]) begin
            r.green = ROAD_B;
        end else if (vd[2]) begin
            r.green = ROAD_C;
        end else begin
            r.green = ROAD_NONE;
        end
        return r;
    endfunction

    function automatic logic [2:0] road_mask(input road_t road);
        logic [2:0] m;
        case (road)
            ROAD_A:  m = 3'b001;
            ROAD_B:  m = 3'b010;
            ROAD_C:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// Lamp drive lines between the light decoder (master) and the lamp-side monitor (slave).
interface semaforo_monitor_if;
    logic VDA;
    logic VMA;
    logic VDB;
    logic VMB;
    logic VDC;
    logic VMC;

    modport master (output VDA, VMA, VDB, VMB, VDC, VMC);
    modport slave  (input  VDA, VMA, VDB, VMB, VDC, VMC);
endinterface

// File: rtl/semaforo_monitor_lamp_debounce.sv
// Debounces a lamp vector: it is accepted once seen on STABLE_CYCLES+1 consecutive edges.
// accept and vec are combinational so the consumer can register the result on that same edge.
module lamp_debounce #(
    parameter int WIDTH         = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [WIDTH-1:0] lamps,
    output logic [WIDTH-1:0] vec,
    output logic             accept
);
    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] held;
    logic             have;
    logic             held_valid;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             load;

    // Re-accepting the vector already held is suppressed, so a glitch that returns to it is invisible.
    always_comb begin
        load = restart || !have || (lamps != sample);
        if (load) begin
            count_next = '0;
        end else if (count == TARGET) begin
            count_next = count;
        end else begin
            count_next = count + CW'(1);
        end
        accept = (count_next == TARGET) && (load || (count != TARGET))
                 && (restart || !held_valid || (lamps != held));
        vec    = accept ? lamps : held;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample     <= '0;
            held       <= '0;
            have       <= 1'b0;
            held_valid <= 1'b0;
            count      <= '0;
        end else begin
            sample <= lamps;
            have   <= 1'b1;
            count  <= count_next;
            if (accept) begin
                held       <= lamps;
                held_valid <= 1'b1;
            end else if (restart) begin
                held_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Lamp-side monitor: debounces the six lamp lines, tracks the green road, dwell time,
// per-road starvation and sticky safety faults. All outputs are registered.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_WAIT      = 1000,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    semaforo_monitor_if.slave  lamps,
    input  logic               clear_fault,
    output logic [1:0]         green_sel,
    output logic               green_valid,
    output logic               phase_change,
    output logic [CNT_W-1:0]   dwell,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         starve
);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] DWELL_MAX  = '1;

    mon_state_t        state;
    logic [LAMP_W-1:0] lamp_vec;
    logic [LAMP_W-1:0] acc_vec;
    logic              accept;
    logic              restart;
    lamp_info_t        info;
    road_t             run_sel;
    logic [2:0]        green_now;
    logic [2:0]        green_was;
    logic [CNT_W-1:0]  wait_cnt [3];

    assign lamp_vec = {lamps.VDA, lamps.VMA, lamps.VDB, lamps.VMB, lamps.VDC, lamps.VMC};
    assign restart  = (state == FAULT) && clear_fault;

    lamp_debounce #(
        .WIDTH         (LAMP_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .lamps   (lamp_vec),
        .vec     (acc_vec),
        .accept  (accept)
    );

    // run_sel is the green road in force for this edge while staying in RUN.
    always_comb begin
        info      = decode_lamps(acc_vec);
        run_sel   = accept ? info.green : road_t'(green_sel);
        green_now = road_mask(run_sel);
        green_was = road_mask(road_t'(green_sel));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT;
            green_sel    <= 2'b00;
            green_valid  <= 1'b0;
            phase_change <= 1'b0;
            dwell        <= '0;
            fault        <= 1'b0;
            fault_code   <= 2'b00;
            starve       <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            phase_change <= 1'b0;
            case (state)
                WAIT: begin
                    if (accept && info.legal) begin
                        state       <= RUN;
                        green_sel   <= info.green;
                        green_valid <= 1'b1;
                        dwell       <= '0;
                        starve      <= starve & ~road_mask(info.green);
                        for (int i = 0; i < 3; i++) begin
                            wait_cnt[i] <= '0;
                        end
                    end else if (accept) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= fault_code | info.causes;
                    end
                end

                RUN: begin
                    if (accept && !info.legal) begin
                        state       <= FAULT;
                        green_valid <= 1'b0;
                        fault       <= 1'b1;
                        fault_code  <= fault_code | info.causes;
                    end else begin
                        green_sel <= run_sel;
                        if (accept && (run_sel != road_t'(green_sel))) begin
                            phase_change <= 1'b1;
                            dwell        <= '0;
                        end else if (dwell != DWELL_MAX) begin
                            dwell <= dwell + CNT_W'(1);
                        end
                        // A road's red period restarts when it was green until this edge.
                        for (int i = 0; i < 3; i++) begin
                            if (green_now[i]) begin
                                wait_cnt[i] <= '0;
                                starve[i]   <= 1'b0;
                            end else if (accept && green_was[i]) begin
                                wait_cnt[i] <= '0;
                            end else if (wait_cnt[i] != WAIT_LIMIT) begin
                                wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                                if (wait_cnt[i] + CNT_W'(1) == WAIT_LIMIT) begin
                                    starve[i] <= 1'b1;
                                end
                            end
                        end
                    end
                end

                FAULT: begin
                    if (restart) begin
                        state      <= WAIT;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                    end else if (accept && !info.legal) begin
                        fault_code <= fault_code | info.causes;
                    end
                end

                default: state <= WAIT;
            endcase
        end
    end

endmodule
